// File: rtl/arr_arbiter.sv
// rtl/arr_arbiter.sv - round-robin arbiter with lockable bursts and host override for a single-port memory
module arr_arbiter #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 4,
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        host_en,
    input  logic                        host_we,
    input  logic [ADDR_W-1:0]           host_addr,
    input  logic signed [DATA_W-1:0]    host_wdata,
    output logic signed [DATA_W-1:0]    host_rdata,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic signed [DATA_W-1:0]    rsp_data,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic signed [DATA_W-1:0]    mem_wdata,
    input  logic signed [DATA_W-1:0]    mem_rdata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);
    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    typedef enum logic [1:0] {ARB, OWN, HOST} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt, owner, owner_nxt, rd_id;
    logic [3:0]         burst_cnt, burst_nxt;
    logic               rd_pend;
    logic [IDX_W-1:0]   arb_idx, gnt_idx, ptr_wrap;
    logic [IDX_W:0]     cand, ptr_inc;
    logic               arb_found, accept, others_valid;
    logic [NUM_REQ-1:0] sel_oh;

    // Rotating priority search starting at rr_ptr
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!arb_found && req_valid[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        accept  = 1'b0;
        gnt_idx = arb_idx;
        if (rst_n && !host_en) begin
            case (state)
                ARB: accept = arb_found;
                OWN: begin
                    gnt_idx = owner;
                    accept  = req_valid[owner];
                end
                default: accept = 1'b0;
            endcase
        end
    end

    assign sel_oh       = NUM_REQ'(1) << gnt_idx;
    assign others_valid = |(req_valid & ~sel_oh);
    assign ptr_inc      = {1'b0, gnt_idx} + (IDX_W+1)'(1);
    assign ptr_wrap     = (ptr_inc >= NREQ) ? '0 : ptr_inc[IDX_W-1:0];

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        if (accept) rr_nxt = ptr_wrap;
        if (host_en) begin
            state_nxt = HOST;
        end else begin
            case (state)
                HOST: begin
                    state_nxt = ARB;
                    owner_nxt = '0;
                    burst_nxt = '0;
                end
                ARB: begin
                    // A one-transaction burst limit releases immediately when others are waiting
                    if (accept && req_lock[gnt_idx] && !(MAXB == 4'd1 && others_valid)) begin
                        state_nxt = OWN;
                        owner_nxt = gnt_idx;
                        burst_nxt = 4'd1;
                    end
                end
                OWN: begin
                    if (accept && burst_cnt < MAXB) burst_nxt = burst_cnt + 4'd1;
                    if (!req_lock[owner] || (accept && burst_nxt >= MAXB && others_valid)) begin
                        state_nxt = ARB;
                        burst_nxt = '0;
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    always_comb begin
        req_ready = accept ? sel_oh : '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (host_en) begin
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end else if (accept) begin
                mem_we    = req_we[gnt_idx];
                mem_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
                mem_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
            end
        end
    end

    assign host_rdata = mem_rdata;
    assign rsp_valid  = (rd_pend && rst_n) ? (NUM_REQ'(1) << rd_id) : '0;
    assign rsp_data   = (rd_pend && rst_n) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_id     <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            rd_pend   <= accept && !req_we[gnt_idx];
            rd_id     <= gnt_idx;
        end
    end
endmodule

// File: tb/tb_arr_arbiter.sv
// tb/tb_arr_arbiter.sv - directed self-checking bench for arr_arbiter
module tb_arr_arbiter;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               host_en, host_we;
    logic [3:0]         host_addr;
    logic signed [63:0] host_wdata, host_rdata;
    logic [1:0]         req_valid, req_lock, req_we, req_ready, rsp_valid;
    logic [7:0]         req_addr;
    logic [127:0]       req_wdata;
    logic signed [63:0] rsp_data, mem_wdata, mem_rdata;
    logic               mem_we;
    logic [3:0]         mem_addr;
    logic [63:0]        mem [0:15];
    int                 total = 0;
    int                 bad = 0;

    arr_arbiter #(.DATA_W(64), .ADDR_W(4), .NUM_REQ(2), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory, contents mem[i] = 0x100 + i after each reset
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 64'h100 + 64'(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic he, input logic hw, input logic [3:0] ha,
                       input logic [63:0] hd, input logic [1:0] v, input logic [1:0] l,
                       input logic [1:0] w, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
        @(negedge clk);
        rst_n = rn; host_en = he; host_we = hw; host_addr = ha; host_wdata = hd;
        req_valid = v; req_lock = l; req_we = w;
        req_addr = {a1, a0}; req_wdata = {d1, d0};
        #1;
    endtask

    initial begin
        rst_n = 1'b0; host_en = 1'b1; host_we = 1'b1; host_addr = 4'd5; host_wdata = 64'h33;
        req_valid = 2'b11; req_lock = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;

        // reset with host_en high
        cyc(0, 1, 1, 5, 64'h33, 2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp", rsp_valid, 2'b00);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);

        // alternating reads, no lock
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
        chk("rr1_ready", req_ready, 2'b01);
        chk("rr1_addr", mem_addr, 1);
        chk("rr1_rsp", rsp_valid, 2'b00);
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
        chk("rr2_ready", req_ready, 2'b10);
        chk("rr2_addr", mem_addr, 2);
        chk("rr2_rsp", rsp_valid, 2'b01);
        chk("rr2_data", rsp_data, 64'h101);
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
        chk("rr3_ready", req_ready, 2'b01);
        chk("rr3_rsp", rsp_valid, 2'b10);
        chk("rr3_data", rsp_data, 64'h102);
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 2, 0, 0);
        chk("rr4_ready", req_ready, 2'b10);
        chk("rr4_rsp", rsp_valid, 2'b01);
        cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2, 0, 0);
        chk("idle_ready", req_ready, 2'b00);
        chk("idle_we", mem_we, 0);
        chk("idle_addr", mem_addr, 0);
        chk("rr5_rsp", rsp_valid, 2'b10);
        chk("rr5_data", rsp_data, 64'h102);
        cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("norsp_valid", rsp_valid, 2'b00);
        chk("norsp_data", rsp_data, 0);

        // write 7 to addr 3 then read it back
        cyc(1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 3, 0, 64'h7, 0);
        chk("wr_ready", req_ready, 2'b01);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 3);
        chk("wr_wdata", mem_wdata, 64'h7);
        cyc(1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3, 0, 0, 0);
        chk("rd_ready", req_ready, 2'b01);
        chk("rd_we", mem_we, 0);
        chk("wr_norsp", rsp_valid, 2'b00);
        cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("rd_rsp", rsp_valid, 2'b01);
        chk("rd_data", rsp_data, 64'h7);

        // locked burst by requester 1, forced release after 4
        cyc(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 5, 4, 0, 0);
        chk("b1_ready", req_ready, 2'b10);
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b10, 2'b00, 5, 4, 0, 0);
        chk("b2_ready", req_ready, 2'b10);
        chk("b2_data", rsp_data, 64'h104);
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b10, 2'b00, 5, 4, 0, 0);
        chk("b3_ready", req_ready, 2'b10);
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b10, 2'b00, 5, 4, 0, 0);
        chk("b4_ready", req_ready, 2'b10);
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b10, 2'b00, 5, 4, 0, 0);
        chk("b5_ready", req_ready, 2'b01);
        chk("b5_addr", mem_addr, 5);
        chk("b5_rsp", rsp_valid, 2'b10);
        cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("b6_rsp", rsp_valid, 2'b01);
        chk("b6_data", rsp_data, 64'h105);

        // read then host takeover
        cyc(1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 6, 0, 0, 0);
        chk("h0_ready", req_ready, 2'b01);
        cyc(1, 1, 1, 9, 64'h55, 2'b01, 2'b00, 2'b00, 6, 0, 0, 0);
        chk("h1_ready", req_ready, 2'b00);
        chk("h1_we", mem_we, 1);
        chk("h1_addr", mem_addr, 9);
        chk("h1_wdata", mem_wdata, 64'h55);
        chk("h1_rsp", rsp_valid, 2'b01);
        chk("h1_data", rsp_data, 64'h106);
        chk("h1_rdata", host_rdata, 64'h106);
        cyc(1, 1, 0, 9, 0, 2'b01, 2'b00, 2'b00, 6, 0, 0, 0);
        chk("h2_ready", req_ready, 2'b00);
        chk("h2_we", mem_we, 0);
        chk("h2_rsp", rsp_valid, 2'b00);
        cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("h3_rdata", host_rdata, 64'h55);

        // reset while owning with a read pending
        cyc(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0, 7, 0, 0);
        chk("o1_ready", req_ready, 2'b10);
        cyc(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0, 8, 0, 0);
        chk("o2_ready", req_ready, 2'b10);
        chk("o2_data", rsp_data, 64'h107);
        cyc(0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0, 8, 0, 0);
        chk("mr_rsp", rsp_valid, 2'b00);
        chk("mr_ready", req_ready, 2'b00);
        cyc(1, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2, 3, 0, 0);
        chk("pr_ready", req_ready, 2'b01);
        chk("pr_rsp", rsp_valid, 2'b00);
        cyc(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("pr2_rsp", rsp_valid, 2'b01);
        chk("pr2_data", rsp_data, 64'h102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
